// File: rtl/pll_spi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : pll_spi_regbank
// Purpose  : SPI-slave (mode 0) register bank for the PLL control plane.
//            Provides NCH DCO channels with test/divider/control/status
//            registers, burst access with address auto-increment, sticky
//            per-channel status capture and a maskable interrupt.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            ss, sck, mosi       - SPI slave inputs (asynchronous to clk)
//            miso, miso_oe       - SPI data out and its output enable
//            dco_tst_reg[8*NCH]  - per-channel test registers
//            div_reg[8*NCH]      - per-channel divider values
//            div_en[2*NCH]       - per-channel {en2,en1}
//            dco_upd[NCH]        - per-channel update strobes
//            dco_sts[8*NCH]      - per-channel live status
//            irq                 - registered interrupt
// Revision : 1.0 - initial release
// ============================================================================
module pll_spi_regbank #(
    parameter int          NCH     = 4,
    parameter logic [7:0]  ID_VAL  = 8'hA5,
    parameter logic [7:0]  TST_RST = 8'h00,
    parameter logic [7:0]  DIV_RST = 8'h01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ss,
    input  logic               sck,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic [8*NCH-1:0]   dco_tst_reg,
    output logic [8*NCH-1:0]   div_reg,
    output logic [2*NCH-1:0]   div_en,
    input  logic [NCH-1:0]     dco_upd,
    input  logic [8*NCH-1:0]   dco_sts,
    output logic               irq
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers and sck edge detection
    // ------------------------------------------------------------------
    logic [1:0] r_ss_s;
    logic [1:0] r_sck_s;
    logic [1:0] r_mosi_s;
    logic       r_sck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_s   <= 2'b11;   // idle level of ss, so reset exit is not a frame start
            r_sck_s  <= 2'b00;
            r_mosi_s <= 2'b00;
            r_sck_d  <= 1'b0;
        end else begin
            r_ss_s   <= {r_ss_s[0], ss};
            r_sck_s  <= {r_sck_s[0], sck};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_sck_d  <= r_sck_s[1];
        end
    end

    logic w_ss;
    logic w_sck_rise;
    logic w_sck_fall;
    assign w_ss       = r_ss_s[1];
    assign w_sck_rise =  r_sck_s[1] & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s[1] &  r_sck_d;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [8*NCH-1:0] r_tst;
    logic [8*NCH-1:0] r_div;
    logic [2*NCH-1:0] r_en;
    logic [8*NCH-1:0] r_sts;
    logic [NCH-1:0]   r_irq_sts;
    logic [NCH-1:0]   r_irq_msk;
    logic [NCH-1:0]   r_upd_d;
    logic             r_irq;

    logic             r_wr_stb;
    logic [6:0]       r_wr_addr;
    logic [7:0]       r_wr_data;

    // Read mux: returns the current value of the register at address a.
    function automatic logic [7:0] rd_mux(input logic [6:0] a);
        logic [7:0] d;
        d = 8'h00;
        case (a)
            7'h00:   d = ID_VAL;
            7'h01:   d = 8'(r_irq_sts);
            7'h02:   d = 8'(r_irq_msk);
            default: d = 8'h00;
        endcase
        for (int c = 0; c < NCH; c++) begin
            // Channel c occupies the 4-byte slot starting at 0x10 + 4c.
            if (a[6:2] == 5'(4 + c)) begin
                case (a[1:0])
                    2'd0:    d = r_tst[8*c +: 8];
                    2'd1:    d = r_div[8*c +: 8];
                    2'd2:    d = {6'b0, r_en[2*c +: 2]};
                    default: d = r_sts[8*c +: 8];
                endcase
            end
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // SPI frame state machine
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_cnt;        // sck rises seen in the current byte
    logic [6:0] r_sin;        // last 7 bits shifted in
    logic [7:0] r_sout;
    logic       r_rw;
    logic [6:0] r_addr;

    logic [7:0] w_byte;
    logic [6:0] w_addr_nxt;
    assign w_byte     = {r_sin, r_mosi_s[1]};
    assign w_addr_nxt = 7'(r_addr + 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 3'd0;
            r_sin     <= 7'd0;
            r_sout    <= 8'd0;
            r_rw      <= 1'b0;
            r_addr    <= 7'd0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 7'd0;
            r_wr_data <= 8'd0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_ss) begin
                // Frame ended: any partial byte is dropped without a write.
                r_state <= c_st_idle;
                r_cnt   <= 3'd0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state <= c_st_cmd;
                        r_cnt   <= 3'd0;
                    end
                    c_st_cmd: begin
                        if (w_sck_rise) begin
                            r_sin <= w_byte[6:0];
                            r_cnt <= 3'(r_cnt + 3'd1);
                            if (r_cnt == 3'd7) begin
                                r_rw    <= w_byte[7];
                                r_addr  <= w_byte[6:0];
                                r_state <= c_st_data;
                                if (w_byte[7]) begin
                                    r_sout <= rd_mux(w_byte[6:0]);
                                end
                            end
                        end
                    end
                    c_st_data: begin
                        if (w_sck_rise) begin
                            r_sin <= w_byte[6:0];
                            r_cnt <= 3'(r_cnt + 3'd1);
                            if (r_cnt == 3'd7) begin
                                r_addr <= w_addr_nxt;
                                if (r_rw) begin
                                    r_sout <= rd_mux(w_addr_nxt);
                                end else begin
                                    r_wr_stb  <= 1'b1;
                                    r_wr_addr <= r_addr;
                                    r_wr_data <= w_byte;
                                end
                            end
                        end
                        // The fall that follows a byte's last rise must not
                        // shift, otherwise the freshly loaded MSB is lost.
                        if (w_sck_fall && r_rw && (r_cnt != 3'd0)) begin
                            r_sout <= {r_sout[6:0], 1'b0};
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Register writes, status capture and interrupt
    // ------------------------------------------------------------------
    logic [NCH-1:0] w_upd_rise;
    logic [NCH-1:0] w_irq_clr;
    assign w_upd_rise = dco_upd & ~r_upd_d;
    assign w_irq_clr  = (r_wr_stb && (r_wr_addr == 7'h01)) ? r_wr_data[NCH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tst     <= {NCH{TST_RST}};
            r_div     <= {NCH{DIV_RST}};
            r_en      <= '0;
            r_sts     <= '0;
            r_irq_sts <= '0;
            r_irq_msk <= '0;
            r_upd_d   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_upd_d <= dco_upd;
            // A capture in the same cycle as the clear keeps the flag set.
            r_irq_sts <= (r_irq_sts & ~w_irq_clr) | w_upd_rise;
            r_irq     <= |(r_irq_sts & r_irq_msk);
            if (r_wr_stb && (r_wr_addr == 7'h02)) begin
                r_irq_msk <= r_wr_data[NCH-1:0];
            end
            for (int c = 0; c < NCH; c++) begin
                if (r_wr_stb && (r_wr_addr == 7'(16 + 4*c))) begin
                    r_tst[8*c +: 8] <= r_wr_data;
                end
                if (r_wr_stb && (r_wr_addr == 7'(17 + 4*c))) begin
                    r_div[8*c +: 8] <= r_wr_data;
                end
                if (r_wr_stb && (r_wr_addr == 7'(18 + 4*c))) begin
                    r_en[2*c +: 2] <= r_wr_data[1:0];
                end
                if (w_upd_rise[c]) begin
                    r_sts[8*c +: 8] <= dco_sts[8*c +: 8];
                end
            end
        end
    end

    assign dco_tst_reg = r_tst;
    assign div_reg     = r_div;
    assign div_en      = r_en;
    assign irq         = r_irq;
    assign miso        = (r_state == c_st_data) && r_rw && r_sout[7];
    assign miso_oe     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_pll_spi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_spi_regbank
// Purpose  : Self-checking bench for pll_spi_regbank (NCH = 4). A table of
//            single-register write/readback vectors plus directed sequences
//            for bursts, status capture, W1C/capture collision, aborted
//            frames and address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_spi_regbank;

    localparam int NCH = 4;
    localparam int H   = 8;     // sck half period in clk cycles

    logic             clk;
    logic             rst_n;
    logic             ss;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [8*NCH-1:0] dco_tst_reg;
    logic [8*NCH-1:0] div_reg;
    logic [2*NCH-1:0] div_en;
    logic [NCH-1:0]   dco_upd;
    logic [8*NCH-1:0] dco_sts;
    logic             irq;

    pll_spi_regbank #(
        .NCH     (NCH),
        .ID_VAL  (8'hA5),
        .TST_RST (8'h00),
        .DIV_RST (8'h01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ss          (ss),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .dco_tst_reg (dco_tst_reg),
        .div_reg     (div_reg),
        .div_en      (div_en),
        .dco_upd     (dco_upd),
        .dco_sts     (dco_sts),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8*NCH-1:0] snap_div;
    logic [8*NCH-1:0] snap_tst;
    logic [2*NCH-1:0] snap_en;
    logic [7:0]       bbuf [8];

    typedef struct {
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Shift nbits of tx MSB first; rx collects miso sampled just before each rise.
    // Outputs are snapshotted 6 clk after every rise to check write latency.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (H) @(negedge clk);
            rx[7-i] = miso;
            sck = 1'b1;
            repeat (6) @(negedge clk);
            snap_div = div_reg;
            snap_tst = dco_tst_reg;
            snap_en  = div_en;
            repeat (H-6) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Burst: command byte then n data bytes from/into bbuf.
    task automatic burst(input logic rw, input logic [6:0] addr, input int n);
        logic [7:0] rx;
        frame_begin();
        spi_bits({rw, addr}, 8, rx);
        for (int k = 0; k < n; k++) begin
            spi_bits(rw ? 8'h00 : bbuf[k], 8, rx);
            if (rw) bbuf[k] = rx;
        end
        frame_end();
    endtask

    task automatic wr_reg(input logic [6:0] addr, input logic [7:0] data);
        bbuf[0] = data;
        burst(1'b0, addr, 1);
    endtask

    task automatic rd_reg(input logic [6:0] addr, output logic [7:0] data);
        burst(1'b1, addr, 1);
        data = bbuf[0];
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rx;
        bit         seen;

        vecs[0] = '{addr: 7'h14, wdata: 8'hAB, exp: 8'hAB};  // TST1
        vecs[1] = '{addr: 7'h15, wdata: 8'h5E, exp: 8'h5E};  // DIV1
        vecs[2] = '{addr: 7'h16, wdata: 8'hFF, exp: 8'h03};  // CTRL1, upper bits read 0
        vecs[3] = '{addr: 7'h17, wdata: 8'h55, exp: 8'h00};  // STS1 is read-only
        vecs[4] = '{addr: 7'h00, wdata: 8'h12, exp: 8'hA5};  // ID is read-only
        vecs[5] = '{addr: 7'h02, wdata: 8'hFF, exp: 8'h0F};  // MSK, bits >= NCH read 0
        vecs[6] = '{addr: 7'h20, wdata: 8'h77, exp: 8'h00};  // channel 4 absent
        vecs[7] = '{addr: 7'h02, wdata: 8'h00, exp: 8'h00};  // MSK back to 0

        rst_n   = 1'b0;
        ss      = 1'b1;
        sck     = 1'b0;
        mosi    = 1'b0;
        dco_upd = '0;
        dco_sts = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1. Reset state and ID read
        check("rst_div",     32'(div_reg),     32'h01010101);
        check("rst_tst",     32'(dco_tst_reg), 32'h00000000);
        check("rst_en",      32'(div_en),      32'h0);
        check("rst_irq",     32'(irq),         32'h0);
        check("rst_miso_oe", 32'(miso_oe),     32'h0);
        frame_begin();
        check("miso_oe_frame", 32'(miso_oe), 32'h1);
        frame_end();
        check("miso_oe_idle", 32'(miso_oe), 32'h0);
        rd_reg(7'h00, rd);
        check("id_read", 32'(rd), 32'hA5);

        // 2. Single write to DIV2, checked shortly after the last rise
        wr_reg(7'h19, 8'h3C);
        check("div2_latency", 32'(snap_div), 32'h013C0101);
        check("div2_tst",     32'(dco_tst_reg), 32'h0);
        check("div2_en",      32'(div_en),      32'h0);

        // 3. Burst write into channel 0, burst readback
        bbuf[0] = 8'h11; bbuf[1] = 8'h22; bbuf[2] = 8'h03;
        burst(1'b0, 7'h10, 3);
        check("bw_tst0", 32'(dco_tst_reg[7:0]), 32'h11);
        check("bw_div0", 32'(div_reg[7:0]),     32'h22);
        check("bw_en0",  32'(div_en[1:0]),      32'h3);
        burst(1'b1, 7'h10, 4);
        check("br_0", 32'(bbuf[0]), 32'h11);
        check("br_1", 32'(bbuf[1]), 32'h22);
        check("br_2", 32'(bbuf[2]), 32'h03);
        check("br_3", 32'(bbuf[3]), 32'h00);

        // Table-driven single-register write/readback
        for (int v = 0; v < 8; v++) begin
            wr_reg(vecs[v].addr, vecs[v].wdata);
            rd_reg(vecs[v].addr, rd);
            check($sformatf("vec%0d_a%02h", v, vecs[v].addr), 32'(rd), 32'(vecs[v].exp));
        end
        check("vec_tst1_out", 32'(dco_tst_reg[15:8]), 32'hAB);
        check("vec_en1_out",  32'(div_en[3:2]),       32'h3);

        // 4. Status capture, interrupt, W1C and capture/clear collision
        wr_reg(7'h02, 8'h04);
        check("irq_masked_idle", 32'(irq), 32'h0);
        @(negedge clk);
        dco_sts[23:16] = 8'h5A;
        dco_upd[2]     = 1'b1;
        repeat (2) @(negedge clk);
        dco_upd[2]     = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        rd_reg(7'h1B, rd);
        check("sts2", 32'(rd), 32'h5A);
        rd_reg(7'h01, rd);
        check("irq_sts", 32'(rd), 32'h04);
        rd_reg(7'h01, rd);
        check("irq_sts_read_keeps", 32'(rd), 32'h04);
        wr_reg(7'h01, 8'h04);
        check("irq_clr", 32'(irq), 32'h0);
        rd_reg(7'h01, rd);
        check("irq_sts_clr", 32'(rd), 32'h00);

        seen = 1'b0;
        fork
            wr_reg(7'h01, 8'h04);
            begin
                for (int t = 0; t < 2000 && !seen; t++) begin
                    @(negedge clk);
                    if (dut.r_wr_stb) begin
                        dco_upd[2] = 1'b1;
                        seen = 1'b1;
                    end
                end
            end
        join
        check("collision_stb_seen", 32'(seen), 32'h1);
        dco_upd[2] = 1'b0;
        rd_reg(7'h01, rd);
        check("collision_set_wins", 32'(rd), 32'h04);
        check("collision_irq", 32'(irq), 32'h1);

        // 5. Aborted write after 5 data bits, then a fresh frame
        frame_begin();
        spi_bits(8'h11, 8, rx);
        spi_bits(8'hFF, 5, rx);
        frame_end();
        check("abort_div0", 32'(div_reg[7:0]), 32'h22);
        rd_reg(7'h11, rd);
        check("abort_next_frame", 32'(rd), 32'h22);

        // 6. Address wrap 0x7F -> 0x00
        burst(1'b1, 7'h7F, 2);
        check("wrap_7f", 32'(bbuf[0]), 32'h00);
        check("wrap_00", 32'(bbuf[1]), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
